// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, idle high) fed by a small circular FIFO.
// Bytes are queued on wr_valid/wr_ready and sent back to back while the queue is non-empty.
module uart_tx_fifo #(
    parameter int sysclk_frequency = 1250,
    parameter int baud             = 115200,
    parameter int fifo_depth_log2  = 3
) (
    input  logic                     clk,
    input  logic                     reset_in,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     txd,
    output logic [fifo_depth_log2:0] fifo_count,
    output logic                     idle
);

    localparam int DEPTH   = 1 << fifo_depth_log2;
    localparam int DIV     = (sysclk_frequency * 100000) / baud;
    localparam int DIV_W   = $clog2(DIV + 1);
    localparam int CNT_W   = (DIV_W > 16) ? DIV_W : 16;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
    localparam logic [fifo_depth_log2:0] FULL_COUNT = {1'b1, {fifo_depth_log2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    tx_state_t                  state;
    logic [7:0]                 mem [DEPTH];
    logic [fifo_depth_log2-1:0] wr_ptr;
    logic [fifo_depth_log2-1:0] rd_ptr;
    logic [7:0]                 shift_reg;
    logic [2:0]                 bit_idx;
    logic [CNT_W-1:0]           baud_cnt;
    logic                       push;
    logic                       pop;
    logic                       bit_done;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign wr_ready = (fifo_count != FULL_COUNT);
    assign push     = wr_valid && wr_ready;
    assign bit_done = (baud_cnt == '0);
    assign pop      = (fifo_count != '0) && ((state == IDLE) || (state == STOP && bit_done));
    assign idle     = (state == IDLE) && (fifo_count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A pop always starts a new frame, whether leaving IDLE or closing a STOP bit.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state     <= IDLE;
            txd       <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else if (pop) begin
            state     <= START;
            shift_reg <= mem[rd_ptr];
            txd       <= 1'b0;
            bit_idx   <= '0;
            baud_cnt  <= DIV_M1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                end
                START: begin
                    if (bit_done) begin
                        state     <= DATA;
                        txd       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= '0;
                        baud_cnt  <= DIV_M1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            txd       <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a DIV=4 instance for frame/FIFO/reset behaviour
// and a default-parameter instance for full-rate frame timing.
module tb_uart_tx_fifo;

    localparam int DIV     = 4;
    localparam int DEF_DIV = 1085;

    logic       clk = 1'b0;
    logic       reset_in;
    logic [7:0] wr_data, wr_data_def;
    logic       wr_valid, wr_valid_def;
    logic       wr_ready, wr_ready_def;
    logic       txd, txd_def;
    logic       idle, idle_def;
    logic [3:0] fifo_count, fifo_count_def;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } frame_vec_t;

    frame_vec_t vecs [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.sysclk_frequency(4), .baud(100000), .fifo_depth_log2(3)) dut (
        .clk(clk), .reset_in(reset_in), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .txd(txd), .fifo_count(fifo_count), .idle(idle)
    );

    uart_tx_fifo dut_def (
        .clk(clk), .reset_in(reset_in), .wr_data(wr_data_def), .wr_valid(wr_valid_def),
        .wr_ready(wr_ready_def), .txd(txd_def), .fifo_count(fifo_count_def), .idle(idle_def)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Mid-bit sampling receiver; start_cyc is the cycle stamp of the first low sample.
    task automatic recv_frame(input bit use_def, input int div, input int budget,
                              output logic [7:0] b, output int start_cyc,
                              output bit stop_ok, output bit timed_out);
        int waited;
        waited    = 0;
        b         = '0;
        start_cyc = 0;
        stop_ok   = 1'b0;
        timed_out = 1'b0;
        @(negedge clk);
        while ((use_def ? txd_def : txd) !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if ((use_def ? txd_def : txd) !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        start_cyc = cyc;
        repeat (div / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            repeat (div) @(negedge clk);
            b[j] = use_def ? txd_def : txd;
        end
        repeat (div) @(negedge clk);
        stop_ok = ((use_def ? txd_def : txd) === 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        int         st [10];
        int         c0, s1, s2, end_c, waited, lows;
        bit         sok, tmo;
        logic [7:0] b1, b2;
        bit         sok1, sok2, tmo1, tmo2;

        // Frame bits listed stop..start: {1, d7..d0, 0}
        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'hA5, 10'b1101001010};
        vecs[2] = '{8'h01, 10'b1000000010};
        vecs[3] = '{8'h80, 10'b1100000000};
        vecs[4] = '{8'h00, 10'b1000000000};

        reset_in     = 1'b1;
        wr_data      = '0;
        wr_valid     = 1'b0;
        wr_data_def  = '0;
        wr_valid_def = 1'b0;
        #2 reset_in  = 1'b0;

        @(negedge clk);
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_wr_ready", wr_ready, 1);
        checkOutput("reset_fifo_count", fifo_count, 0);
        checkOutput("reset_idle", idle, 1);
        checkOutput("reset_def_txd", txd_def, 1);
        @(negedge clk);
        reset_in = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_txd", txd, 1);
        checkOutput("post_reset_idle", idle, 1);

        // Single frames from the vector table, checked on every clock of the frame
        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k].data);
            checkOutput($sformatf("v%0d_queued_count", k), fifo_count, 1);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                checkOutput($sformatf("v%0d_txd_cyc%0d", k, i), txd, vecs[k].frame[i / DIV]);
                if (i == 0) begin
                    checkOutput($sformatf("v%0d_popped_count", k), fifo_count, 0);
                end
            end
            @(negedge clk);
            checkOutput($sformatf("v%0d_idle_after", k), idle, 1);
        end

        // Burst 0x01..0x09, then a write against a full FIFO at the STOP-to-START pop
        fork
            begin
                @(negedge clk);
                c0       = cyc;
                wr_data  = 8'h01;
                wr_valid = 1'b1;
                for (int b = 2; b <= 9; b++) begin
                    @(negedge clk);
                    wr_data = 8'(b);
                end
                @(negedge clk);
                wr_valid = 1'b0;
                checkOutput("burst_count_full", fifo_count, 8);
                checkOutput("burst_wr_ready_full", wr_ready, 0);
                waited = 0;
                while (cyc != c0 + 41 && waited < 100) begin
                    @(negedge clk);
                    waited++;
                end
                wr_data  = 8'h0A;
                wr_valid = 1'b1;
                checkOutput("full_wr_ready_before_pop", wr_ready, 0);
                checkOutput("full_count_before_pop", fifo_count, 8);
                @(negedge clk);
                checkOutput("full_count_after_pop", fifo_count, 7);
                checkOutput("full_wr_ready_after_pop", wr_ready, 1);
                @(negedge clk);
                wr_valid = 1'b0;
                checkOutput("full_count_after_retry", fifo_count, 8);
            end
            begin
                for (int f = 0; f < 10; f++) begin
                    recv_frame(1'b0, DIV, 200, rb, st[f], sok, tmo);
                    checkOutput($sformatf("burst%0d_timeout", f), tmo, 0);
                    checkOutput($sformatf("burst%0d_byte", f), rb, 32'(f + 1));
                    checkOutput($sformatf("burst%0d_stop", f), sok, 1);
                    if (f > 0) begin
                        checkOutput($sformatf("burst%0d_spacing", f), st[f] - st[f - 1], 40);
                    end
                end
            end
        join
        waited = 0;
        while (idle !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("burst_idle_end", idle, 1);

        // Reset during DATA bit 3 of 0xA5 with five bytes queued behind it
        @(negedge clk);
        c0       = cyc;
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            wr_data = 8'h11 + 8'(b);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        waited   = 0;
        while (cyc != c0 + 19 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("mid_frame_bit3", txd, 0);
        checkOutput("mid_frame_count", fifo_count, 5);
        reset_in = 1'b0;
        #1;
        checkOutput("async_reset_txd", txd, 1);
        checkOutput("async_reset_count", fifo_count, 0);
        checkOutput("async_reset_idle", idle, 1);
        checkOutput("async_reset_wr_ready", wr_ready, 1);
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        lows     = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1 || idle !== 1'b1) lows++;
        end
        checkOutput("no_frame_after_reset", lows, 0);

        // Default parameters: 0xFF then 0x00, full-rate frame timing
        fork
            begin
                @(negedge clk);
                wr_data_def  = 8'hFF;
                wr_valid_def = 1'b1;
                @(negedge clk);
                wr_data_def  = 8'h00;
                @(negedge clk);
                wr_valid_def = 1'b0;
            end
            begin
                recv_frame(1'b1, DEF_DIV, 50, b1, s1, sok1, tmo1);
                recv_frame(1'b1, DEF_DIV, 2000, b2, s2, sok2, tmo2);
                waited = 0;
                while (idle_def !== 1'b1 && waited < 3000) begin
                    @(negedge clk);
                    waited++;
                end
                end_c = cyc;
            end
        join
        checkOutput("def_ff_timeout", tmo1, 0);
        checkOutput("def_ff_byte", b1, 32'hFF);
        checkOutput("def_ff_stop", sok1, 1);
        checkOutput("def_00_timeout", tmo2, 0);
        checkOutput("def_00_byte", b2, 32'h00);
        checkOutput("def_00_stop", sok2, 1);
        checkOutput("def_ff_frame_len", s2 - s1, 10850);
        checkOutput("def_00_frame_len", end_c - s2, 10850);
        checkOutput("def_idle_end", idle_def, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
